// File: rtl/alu_issue_pkg.sv
// Shared ALUctl encodings and RV32I decode tables for the ALU issue stage.
package alu_issue_pkg;

  // ALUctl[3:0]: ALU operation
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD  = 4'd0;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB  = 4'd1;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLL  = 4'd2;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLT  = 4'd3;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLTU = 4'd4;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_XOR  = 4'd5;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRL  = 4'd6;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA  = 4'd7;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_OR   = 4'd8;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_AND  = 4'd9;

  // ALUctl[6:4]: branch condition
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE = 3'd0;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BEQ  = 3'd1;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BNE  = 3'd2;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLT  = 3'd3;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGE  = 3'd4;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLTU = 3'd5;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGEU = 3'd6;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_t;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;
  } issue_t;

  // alt selects SUB/SRA; the caller decides when instr[30] is honoured
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB : kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD;
      3'b001:  return kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLL;
      3'b010:  return kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLT;
      3'b011:  return kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLTU;
      3'b100:  return kSAIL_MICROARCHITECTURE_ALUCTL_3to0_XOR;
      3'b101:  return alt ? kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA : kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRL;
      3'b110:  return kSAIL_MICROARCHITECTURE_ALUCTL_3to0_OR;
      default: return kSAIL_MICROARCHITECTURE_ALUCTL_3to0_AND;
    endcase
  endfunction

  function automatic logic [31:0] imm_sel(input logic [31:0] i, input imm_t t);
    case (t)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {27'b0, i[24:20]};
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream (register read) and downstream (execute) handshake bundle of the issue stage.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_ctl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_illegal;

  modport master (output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
                  input  in_ready, out_valid, out_ctl, out_a, out_b, out_illegal);
  modport slave  (input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
                  output in_ready, out_valid, out_ctl, out_a, out_b, out_illegal);
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALUctl and operands A/B.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output issue_t      res
);
  logic [2:0] f3;
  logic       is_sh;
  assign f3    = instr[14:12];
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    res = '0;
    case (instr[6:0])
      OPC_OP: begin
        res.ctl = {kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE, f3_op(f3, instr[30])};
        res.a   = rs1;
        res.b   = rs2;
      end
      OPC_OP_IMM: begin
        // only SRAI honours instr[30]; ADDI never turns into SUB
        res.ctl = {kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE, f3_op(f3, instr[30] && (f3 == 3'b101))};
        res.a   = rs1;
        res.b   = imm_sel(instr, is_sh ? IMM_SH : IMM_I);
      end
      OPC_LOAD, OPC_JALR: begin
        res.ctl = {kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD};
        res.a   = rs1;
        res.b   = imm_sel(instr, IMM_I);
      end
      OPC_STORE: begin
        res.ctl = {kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD};
        res.a   = rs1;
        res.b   = imm_sel(instr, IMM_S);
      end
      OPC_BRANCH: begin
        res.a = rs1;
        res.b = rs2;
        case (f3)
          3'b000:  res.ctl[6:4] = kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BEQ;
          3'b001:  res.ctl[6:4] = kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BNE;
          3'b100:  res.ctl[6:4] = kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLT;
          3'b101:  res.ctl[6:4] = kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGE;
          3'b110:  res.ctl[6:4] = kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLTU;
          3'b111:  res.ctl[6:4] = kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGEU;
          default: res.illegal  = 1'b1;
        endcase
        if (res.illegal) begin
          res.a = '0;
          res.b = '0;
        end else begin
          res.ctl[3:0] = kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB;
        end
      end
      OPC_LUI: begin
        res.ctl = {kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD};
        res.b   = imm_sel(instr, IMM_U);
      end
      OPC_AUIPC: begin
        res.ctl = {kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD};
        res.a   = pc;
        res.b   = imm_sel(instr, IMM_U);
      end
      OPC_JAL: begin
        res.ctl = {kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD};
        res.a   = pc;
        res.b   = imm_sel(instr, IMM_J);
      end
      default: res.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// Registered ALU issue stage. ALU_ISSUE_SKID_EN selects a two-entry skid buffer with
// registered in_ready; otherwise a single output register with pass-through ready.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  alu_issue_if.slave  io
);
  issue_t dec, main_q;
  logic   out_valid_q, acc, cons;

  alu_issue_decode u_dec (
    .instr (io.in_instr),
    .pc    (io.in_pc),
    .rs1   (io.in_rs1),
    .rs2   (io.in_rs2),
    .res   (dec)
  );

  assign acc            = io.in_valid && io.in_ready;
  assign cons           = out_valid_q && io.out_ready;
  assign io.out_valid   = out_valid_q;
  assign io.out_ctl     = main_q.ctl;
  assign io.out_a       = main_q.a;
  assign io.out_b       = main_q.b;
  assign io.out_illegal = main_q.illegal;

`ifdef ALU_ISSUE_SKID_EN
  occ_t   state;
  issue_t skid_q;
  logic   rdy_q;

  assign io.in_ready = rdy_q && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state       <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      case (state)
        OCC_EMPTY:
          if (acc) begin
            main_q      <= dec;
            out_valid_q <= 1'b1;
            state       <= OCC_ONE;
          end
        OCC_ONE:
          if (acc && cons) begin
            main_q <= dec;
          end else if (acc) begin
            skid_q <= dec;
            rdy_q  <= 1'b0;
            state  <= OCC_TWO;
          end else if (cons) begin
            out_valid_q <= 1'b0;
            state       <= OCC_EMPTY;
          end
        OCC_TWO:
          if (cons) begin
            main_q <= skid_q;
            rdy_q  <= 1'b1;
            state  <= OCC_ONE;
          end
        default: state <= OCC_EMPTY;
      endcase
    end
  end
`else
  assign io.in_ready = !flush && !reset && (!out_valid_q || io.out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      main_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (acc) begin
      main_q      <= dec;
      out_valid_q <= 1'b1;
    end else if (cons) begin
      out_valid_q <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue against a queue-based reference model.
module tb_alu_issue;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  int   total = 0, bad = 0;
  issue_t q[$];

  alu_issue_if io ();
  alu_issue dut (.clk(clk), .reset(reset), .flush(flush), .io(io.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural decode written from the ISA rules with plain arithmetic.
  function automatic issue_t ref_dec(input logic [31:0] i, pc, r1, r2);
    issue_t e;
    logic [31:0] imm_i, imm_s, imm_u, imm_j, shamt;
    logic [3:0]  op_tab [8];
    logic [2:0]  br_tab [8];
    logic [3:0]  op;
    int f3;
    op_tab = '{kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLL,
               kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLT, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLTU,
               kSAIL_MICROARCHITECTURE_ALUCTL_3to0_XOR, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRL,
               kSAIL_MICROARCHITECTURE_ALUCTL_3to0_OR,  kSAIL_MICROARCHITECTURE_ALUCTL_3to0_AND};
    br_tab = '{kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BEQ,  kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BNE,
               3'd0, 3'd0,
               kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLT,  kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGE,
               kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLTU, kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGEU};
    f3    = int'((i >> 12) & 32'h7);
    imm_i = 32'($signed(i) >>> 20);
    imm_s = (imm_i & 32'hFFFF_FFE0) | ((i >> 7) & 32'h1F);
    imm_u = i & 32'hFFFF_F000;
    imm_j = (32'($signed(i) >>> 11) & 32'hFFF0_0000) | (i & 32'h000F_F000)
          | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
    shamt = (i >> 20) & 32'h1F;
    e = '0;
    case (i & 32'h7F)
      32'h33: begin
        op = op_tab[f3];
        if (i[30] && f3 == 0) op = kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB;
        if (i[30] && f3 == 5) op = kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA;
        e.ctl = {3'd0, op}; e.a = r1; e.b = r2;
      end
      32'h13: begin
        op = op_tab[f3];
        if (i[30] && f3 == 5) op = kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA;
        e.ctl = {3'd0, op}; e.a = r1; e.b = (f3 == 1 || f3 == 5) ? shamt : imm_i;
      end
      32'h03, 32'h67: begin e.ctl = {3'd0, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD}; e.a = r1; e.b = imm_i; end
      32'h23: begin e.ctl = {3'd0, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD}; e.a = r1; e.b = imm_s; end
      32'h63: begin
        if (f3 == 2 || f3 == 3) e.illegal = 1'b1;
        else begin e.ctl = {br_tab[f3], kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB}; e.a = r1; e.b = r2; end
      end
      32'h37: begin e.ctl = {3'd0, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD}; e.b = imm_u; end
      32'h17: begin e.ctl = {3'd0, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD}; e.a = pc; e.b = imm_u; end
      32'h6F: begin e.ctl = {3'd0, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD}; e.a = pc; e.b = imm_j; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [14];
    logic [31:0] i;
    opcs = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h63,
             7'h37, 7'h17, 7'h6F, 7'h7F, 7'h73};
    i = $urandom;
    i[6:0] = opcs[$urandom_range(0, 13)];
    return i;
  endfunction

  // One cycle: check outputs against the model head, drive inputs, check in_ready, advance.
  task automatic step(input logic v, input logic [31:0] ins, pc, r1, r2,
                      input logic ordy, input logic fl);
    logic exp_rdy;
    chk("out_valid", 32'(io.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_ctl", 32'(io.out_ctl), 32'(q[0].ctl));
      chk("out_a", io.out_a, q[0].a);
      chk("out_b", io.out_b, q[0].b);
      chk("out_illegal", 32'(io.out_illegal), 32'(q[0].illegal));
    end
    io.in_valid = v; io.in_instr = ins; io.in_pc = pc; io.in_rs1 = r1; io.in_rs2 = r2;
    io.out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (SKID ? (q.size() < 2) : (q.size() == 0 || ordy));
    chk("in_ready", 32'(io.in_ready), 32'(exp_rdy));
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(ref_dec(ins, pc, r1, r2));
    end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; io.in_valid = 1'b1; io.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; io.in_valid = 1'b0;
    q.delete();
    chk("rst_valid", 32'(io.out_valid), 32'd0);
    chk("rst_ctl", 32'(io.out_ctl), 32'd0);
    chk("rst_a", io.out_a, 32'd0);
    chk("rst_b", io.out_b, 32'd0);
    chk("rst_illegal", 32'(io.out_illegal), 32'd0);
  endtask

  initial begin
    io.in_valid = 1'b0; io.in_instr = '0; io.in_pc = '0; io.in_rs1 = '0; io.in_rs2 = '0;
    io.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // directed decode cases with literal expectations
    step(1, 32'h0051_0093, 32'h100, 32'h10, 32'h0, 1, 0);
    chk("addi_ctl", 32'(io.out_ctl), 32'h00); chk("addi_a", io.out_a, 32'h10); chk("addi_b", io.out_b, 32'h5);
    step(1, 32'h4031_5093, 32'h104, 32'h8000_0000, 32'h0, 1, 0);
    chk("srai_ctl", 32'(io.out_ctl), 32'h07); chk("srai_b", io.out_b, 32'h3);
    step(1, 32'h4020_80B3, 32'h108, 32'h9, 32'h4, 1, 0);
    chk("sub_ctl", 32'(io.out_ctl), 32'h01);
    step(1, 32'h0020_8463, 32'h10C, 32'h7, 32'h7, 1, 0);
    chk("beq_ctl", 32'(io.out_ctl), 32'h11); chk("beq_a", io.out_a, 32'h7); chk("beq_b", io.out_b, 32'h7);
    step(1, 32'h1234_50B7, 32'h110, 32'h55, 32'h66, 1, 0);
    chk("lui_a", io.out_a, 32'h0); chk("lui_b", io.out_b, 32'h1234_5000);
    step(1, 32'h0000_007F, 32'h114, 32'h55, 32'h66, 1, 0);
    chk("ill_flag", 32'(io.out_illegal), 32'h1); chk("ill_ctl", 32'(io.out_ctl), 32'h0);
    chk("ill_a", io.out_a, 32'h0); chk("ill_b", io.out_b, 32'h0);
    step(0, 0, 0, 0, 0, 1, 0);

    // backpressure: three back-to-back, then drain
    step(1, 32'h0011_0113, 32'h200, 32'h1, 32'h0, 0, 0);
    step(1, 32'h0021_0113, 32'h204, 32'h2, 32'h0, 0, 0);
    step(1, 32'h0031_0113, 32'h208, 32'h3, 32'h0, 0, 0);
    step(1, 32'h0031_0113, 32'h208, 32'h3, 32'h0, 1, 0);
    step(1, 32'h0031_0113, 32'h208, 32'h3, 32'h0, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, 0);

    // flush while full, colliding with input and output transfers
    step(1, 32'h0041_0113, 32'h300, 32'h4, 32'h0, 0, 0);
    step(1, 32'h0051_0113, 32'h304, 32'h5, 32'h0, 0, 0);
    step(1, 32'h0061_0113, 32'h308, 32'h6, 32'h0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0);

    // reset mid-stream
    step(1, 32'h0071_0113, 32'h400, 32'h7, 32'h0, 0, 0);
    step(1, 32'h0081_0113, 32'h404, 32'h8, 32'h0, 0, 0);
    do_reset();

    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
